// File: rtl/tft_spi_tx.sv
// Byte-wide command/data sink that serialises onto the panel's 4-wire SPI bus (mode 0, MSB first).
// Latency: a byte accepted on an edge drives its first bit on that edge; busy stays high for 16*CLK_DIV cycles.
// Backpressure: busy is high through panel reset, power-up wait and each byte; requests seen while busy are dropped.
module tft_spi_tx #(
   parameter int CLK_DIV     = 2,
   parameter int RST_CYCLES  = 1000,
   parameter int WAIT_CYCLES = 5000,
   parameter int CS_HOLD     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       transmit,
   input  logic       dc,
   input  logic [7:0] data,
   output logic       busy,
   output logic       spi_sck,
   output logic       spi_mosi,
   output logic       spi_cs_n,
   output logic       spi_dc,
   output logic       tft_rst_n
);

   // Counter widths are one bit wider than the value they count to, so the
   // terminal compare can be ">=" and a counter never wraps past its limit.
   localparam int SEQ_MAX = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
   localparam int DW      = $clog2(CLK_DIV) + 1;
   localparam int SW      = $clog2(SEQ_MAX) + 1;
   localparam int HW      = $clog2(CS_HOLD) + 1;

   // Terminal counts (count runs 0..N-1); a zero parameter degenerates to a single cycle.
   localparam logic [DW-1:0] DIV_LAST  = DW'((CLK_DIV     > 1) ? CLK_DIV     - 1 : 0);
   localparam logic [SW-1:0] RST_LAST  = SW'((RST_CYCLES  > 1) ? RST_CYCLES  - 1 : 0);
   localparam logic [SW-1:0] WAIT_LAST = SW'((WAIT_CYCLES > 1) ? WAIT_CYCLES - 1 : 0);
   localparam logic [HW-1:0] HOLD_LAST = HW'((CS_HOLD     > 1) ? CS_HOLD     - 1 : 0);

   typedef enum logic [2:0] {
      RST_LO,
      RST_WAIT,
      IDLE,
      SHIFT,
      HOLD
   } state_t;

   state_t        state;
   logic [DW-1:0] div_cnt;    // clk cycles into the current SCK half-period
   logic [SW-1:0] seq_cnt;    // shared by the reset-low and power-up wait phases
   logic [HW-1:0] hold_cnt;   // idle cycles since the last byte finished
   logic [2:0]    bit_idx;    // bit currently on MOSI, 7 down to 0
   logic [6:0]    shreg;      // remaining bits below the one on MOSI, next bit at [6]
   logic          start;

   // A byte may start only from IDLE or HOLD; HOLD starts keep CS# low.
   assign start = transmit && ((state == IDLE) || (state == HOLD));

   // Sequencer: panel reset, power-up wait, byte shifting and CS# hold-off.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RST_LO;
         busy      <= 1'b1;
         spi_sck   <= 1'b0;
         spi_mosi  <= 1'b0;
         spi_cs_n  <= 1'b1;
         spi_dc    <= 1'b0;
         tft_rst_n <= 1'b0;
         div_cnt   <= '0;
         seq_cnt   <= '0;
         hold_cnt  <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
      end else if (start) begin
         state    <= SHIFT;
         shreg    <= data[6:0];
         spi_dc   <= dc;
         busy     <= 1'b1;
         spi_cs_n <= 1'b0;
         spi_mosi <= data[7];
         spi_sck  <= 1'b0;
         div_cnt  <= '0;
         bit_idx  <= 3'd7;
         hold_cnt <= '0;
      end else begin
         case (state)
            RST_LO: begin
               if (seq_cnt >= RST_LAST) begin
                  tft_rst_n <= 1'b1;
                  seq_cnt   <= '0;
                  state     <= RST_WAIT;
               end else begin
                  seq_cnt <= seq_cnt + SW'(1);
               end
            end

            RST_WAIT: begin
               if (seq_cnt >= WAIT_LAST) begin
                  busy    <= 1'b0;
                  seq_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  seq_cnt <= seq_cnt + SW'(1);
               end
            end

            IDLE: begin
               // Waiting for a request; spi_dc and spi_mosi keep their last values.
            end

            SHIFT: begin
               if (div_cnt >= DIV_LAST) begin
                  div_cnt <= '0;
                  spi_sck <= ~spi_sck;
                  // spi_sck high here means this toggle is the falling edge:
                  // the panel has sampled, so move on to the next bit or finish.
                  if (spi_sck) begin
                     if (bit_idx != 3'd0) begin
                        bit_idx  <= bit_idx - 3'd1;
                        spi_mosi <= shreg[6];
                        shreg    <= {shreg[5:0], 1'b0};
                     end else begin
                        state    <= HOLD;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end

            HOLD: begin
               if (hold_cnt >= HOLD_LAST) begin
                  spi_cs_n <= 1'b1;
                  hold_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end

            default: begin
               state <= RST_LO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tft_spi_tx.sv
// Self-checking bench for tft_spi_tx: directed reset/byte/hold cases plus randomized traffic.
// Bytes are recovered from the SPI pins by a bus-level decoder and compared with what the bench sent.
// Two instances: CLK_DIV=2 for timing cases, CLK_DIV=1 for a long streaming run.
module tb_tft_spi_tx;

   localparam int CLK_DIV  = 2;
   localparam int RST_CYC  = 10;
   localparam int WAIT_CYC = 20;
   localparam int HOLD_CYC = 4;
   localparam int N_STREAM = 484;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       a_tx = 1'b0, a_dc = 1'b0;
   logic [7:0] a_data = 8'h00;
   logic       a_busy, a_sck, a_mosi, a_cs_n, a_spi_dc, a_tft_rst_n;

   logic       b_tx = 1'b0, b_dc = 1'b0;
   logic [7:0] b_data = 8'h00;
   logic       b_busy, b_sck, b_mosi, b_cs_n, b_spi_dc, b_tft_rst_n;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tft_spi_tx #(
      .CLK_DIV(CLK_DIV), .RST_CYCLES(RST_CYC), .WAIT_CYCLES(WAIT_CYC), .CS_HOLD(HOLD_CYC)
   ) dut_a (
      .clk(clk), .rst(rst), .transmit(a_tx), .dc(a_dc), .data(a_data),
      .busy(a_busy), .spi_sck(a_sck), .spi_mosi(a_mosi), .spi_cs_n(a_cs_n),
      .spi_dc(a_spi_dc), .tft_rst_n(a_tft_rst_n)
   );

   tft_spi_tx #(
      .CLK_DIV(1), .RST_CYCLES(RST_CYC), .WAIT_CYCLES(WAIT_CYC), .CS_HOLD(HOLD_CYC)
   ) dut_b (
      .clk(clk), .rst(rst), .transmit(b_tx), .dc(b_dc), .data(b_data),
      .busy(b_busy), .spi_sck(b_sck), .spi_mosi(b_mosi), .spi_cs_n(b_cs_n),
      .spi_dc(b_spi_dc), .tft_rst_n(b_tft_rst_n)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // SPI bus decoders: sample MOSI on each SCK rise while CS# is low, 8 bits per byte,
   // and drop any partial byte when CS# goes high.
   logic [8:0] a_q[$];
   int         a_nbits = 0, a_dc_err = 0, a_cs_rises = 0, a_sck_tog = 0;
   logic [7:0] a_sh = 8'h00;
   logic       a_dc0 = 1'b0, a_sck_q = 1'b0, a_cs_q = 1'b1;

   // Decode bus A on the falling clk edge, away from the DUT's active edge.
   always @(negedge clk) begin
      if (a_sck !== a_sck_q) a_sck_tog++;
      if (a_cs_n === 1'b1 && a_cs_q === 1'b0) a_cs_rises++;
      if (a_cs_n !== 1'b0) begin
         a_nbits = 0;
      end else if (a_sck === 1'b1 && a_sck_q === 1'b0) begin
         if (a_nbits == 0) a_dc0 = a_spi_dc;
         else if (a_spi_dc !== a_dc0) a_dc_err++;
         a_sh = {a_sh[6:0], a_mosi};
         a_nbits++;
         if (a_nbits == 8) begin
            a_q.push_back({a_dc0, a_sh});
            a_nbits = 0;
         end
      end
      a_sck_q = a_sck;
      a_cs_q  = a_cs_n;
   end

   logic [8:0] b_q[$];
   int         b_nbits = 0, b_dc_err = 0, b_sck_tog = 0;
   logic [7:0] b_sh = 8'h00;
   logic       b_dc0 = 1'b0, b_sck_q = 1'b0;

   // Decode bus B the same way.
   always @(negedge clk) begin
      if (b_sck !== b_sck_q) b_sck_tog++;
      if (b_cs_n !== 1'b0) begin
         b_nbits = 0;
      end else if (b_sck === 1'b1 && b_sck_q === 1'b0) begin
         if (b_nbits == 0) b_dc0 = b_spi_dc;
         else if (b_spi_dc !== b_dc0) b_dc_err++;
         b_sh = {b_sh[6:0], b_mosi};
         b_nbits++;
         if (b_nbits == 8) begin
            b_q.push_back({b_dc0, b_sh});
            b_nbits = 0;
         end
      end
      b_sck_q = b_sck;
   end

   // Hold rst for 'held' edges, check reset values, then time the reset sequence.
   // Junk requests are pulsed during reset-low and during the power-up wait.
   task automatic do_reset(input int held, input string tag);
      int n_rst, n_busy, cs_low;
      rst = 1'b1;
      repeat (held) tick();
      check({tag, "_busy"},  a_busy, 1);
      check({tag, "_sck"},   a_sck, 0);
      check({tag, "_mosi"},  a_mosi, 0);
      check({tag, "_cs_n"},  a_cs_n, 1);
      check({tag, "_dc"},    a_spi_dc, 0);
      check({tag, "_rst_n"}, a_tft_rst_n, 0);
      rst = 1'b0;
      n_rst = 0; n_busy = 0; cs_low = 0;
      for (int n = 1; n <= 200 && n_busy == 0; n++) begin
         if (n == 3 || n == 15) begin
            a_tx = 1'b1; a_dc = 1'b1; a_data = 8'hFF;
         end
         tick();
         a_tx = 1'b0;
         if (a_tft_rst_n === 1'b1 && n_rst == 0) n_rst = n;
         if (a_busy === 1'b0 && n_busy == 0) n_busy = n;
         if (a_cs_n !== 1'b1) cs_low++;
      end
      check({tag, "_rst_n_rise"}, n_rst, RST_CYC);
      check({tag, "_busy_fall"},  n_busy, RST_CYC + WAIT_CYC);
      check({tag, "_cs_low"},     cs_low, 0);
   endtask

   // Wait for ready (bounded), then present one request for one cycle.
   task automatic send_a(input logic d, input logic [7:0] v);
      int w = 0;
      while (a_busy !== 1'b0 && w < 2000) begin
         tick();
         w++;
      end
      check("send_ready", a_busy, 0);
      a_tx = 1'b1; a_dc = d; a_data = v;
      tick();
      a_tx = 1'b0;
   endtask

   // Count remaining busy cycles, then cycles until CS# releases.
   task automatic measure_byte(output int hi, output int hold);
      hi = 0; hold = 0;
      while (a_busy === 1'b1 && hi < 1000) begin
         hi++;
         tick();
      end
      while (a_cs_n === 1'b0 && hold < 100) begin
         hold++;
         tick();
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi, hold, r0, t0, w, r, stalls, nbad, exp_rises, gap, junk;
      logic prev, d;
      logic [7:0] v;
      logic [8:0] exp_q[$];

      // Power-on reset sequence.
      do_reset(2, "por");
      check("por_no_bytes", a_q.size(), 0);

      // Single command byte 0x2A.
      a_q.delete();
      send_a(1'b0, 8'h2A);
      check("cmd_cs_low", a_cs_n, 0);
      measure_byte(hi, hold);
      check("cmd_busy_len", hi, 16 * CLK_DIV);
      check("cmd_cs_hold", hold, HOLD_CYC);
      check("cmd_count", a_q.size(), 1);
      check("cmd_byte", (a_q.size() > 0) ? a_q[0] : 9'h1FF, 9'h02A);
      check("cmd_mosi_last", a_mosi, 0);

      // Back-to-back command then data byte, second issued on first ready cycle.
      a_q.delete();
      r0 = a_cs_rises; t0 = a_sck_tog;
      send_a(1'b0, 8'h2A);
      send_a(1'b1, 8'h00);
      measure_byte(hi, hold);
      check("b2b_busy_len", hi, 16 * CLK_DIV);
      check("b2b_cs_rises", a_cs_rises - r0, 1);
      check("b2b_sck_edges", a_sck_tog - t0, 32);
      check("b2b_count", a_q.size(), 2);
      check("b2b_byte0", (a_q.size() > 0) ? a_q[0] : 9'h1FF, 9'h02A);
      check("b2b_byte1", (a_q.size() > 1) ? a_q[1] : 9'h1FF, 9'h100);
      check("b2b_dc_stable", a_dc_err, 0);

      // Request while busy is dropped.
      a_q.delete();
      send_a(1'b1, 8'h3C);
      repeat (10) tick();
      a_tx = 1'b1; a_dc = 1'b0; a_data = 8'hFF;
      tick();
      a_tx = 1'b0;
      measure_byte(hi, hold);
      repeat (40) tick();
      check("ign_busy_rest", hi, 16 * CLK_DIV - 11);
      check("ign_count", a_q.size(), 1);
      check("ign_byte", (a_q.size() > 0) ? a_q[0] : 9'h1FF, 9'h13C);

      // Randomized traffic with bench-side timing: a byte takes 16*CLK_DIV cycles,
      // then CS# releases only if CS_HOLD idle cycles pass before the next request.
      a_q.delete();
      exp_q.delete();
      r0 = a_cs_rises;
      exp_rises = 0;
      for (int i = 0; i < 16; i++) begin
         d    = 1'($urandom_range(0, 1));
         v    = 8'($urandom_range(0, 255));
         gap  = $urandom_range(0, 6);
         junk = $urandom_range(1, 16 * CLK_DIV - 3);
         check("rnd_ready", a_busy, 0);
         a_tx = 1'b1; a_dc = d; a_data = v;
         tick();
         a_tx = 1'b0;
         exp_q.push_back({d, v});
         check("rnd_busy", a_busy, 1);
         for (int k = 0; k < 16 * CLK_DIV; k++) begin
            if (k == junk) begin
               a_tx = 1'b1; a_dc = 1'($urandom_range(0, 1)); a_data = 8'($urandom_range(0, 255));
            end
            tick();
            a_tx = 1'b0;
         end
         check("rnd_mosi_last", a_mosi, v[0]);
         if (gap >= HOLD_CYC) exp_rises++;
         repeat (gap) tick();
      end
      repeat (HOLD_CYC + 4) tick();
      exp_rises++;
      check("rnd_count", a_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check("rnd_byte", (i < a_q.size()) ? a_q[i] : 9'h1FF, exp_q[i]);
      check("rnd_cs_rises", a_cs_rises - r0, exp_rises);
      check("rnd_dc_stable", a_dc_err, 0);

      // Reset in the middle of 0xA5 after three SCK rises.
      a_q.delete();
      send_a(1'b0, 8'hA5);
      r = 0; w = 0; prev = a_sck;
      while (r < 3 && w < 200) begin
         tick();
         w++;
         if (a_sck === 1'b1 && prev === 1'b0) r++;
         prev = a_sck;
      end
      check("mid_rises", r, 3);
      do_reset(1, "midrst");
      repeat (5) tick();
      check("mid_no_partial", a_q.size(), 0);

      // Streaming on the CLK_DIV=1 instance, gated only by busy.
      b_q.delete();
      t0 = b_sck_tog;
      stalls = 0;
      for (int i = 0; i < N_STREAM; i++) begin
         w = 0;
         while (b_busy !== 1'b0 && w < 100) begin
            tick();
            w++;
         end
         if (w >= 100) stalls++;
         b_tx = 1'b1; b_dc = 1'b1; b_data = 8'hEE;
         tick();
         b_tx = 1'b0;
      end
      w = 0;
      while (b_cs_n !== 1'b1 && w < 200) begin
         tick();
         w++;
      end
      tick();
      nbad = 0;
      foreach (b_q[i]) if (b_q[i] !== 9'h1EE) nbad++;
      check("stream_stalls", stalls, 0);
      check("stream_cs_release", b_cs_n, 1);
      check("stream_sck_edges", b_sck_tog - t0, N_STREAM * 16);
      check("stream_count", b_q.size(), N_STREAM);
      check("stream_bad_bytes", nbad, 0);
      check("stream_dc_stable", b_dc_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
